// File: rtl/sdram_arbiter_if.sv
// ============================================================================
//  Module      : sdram_arbiter_if
//  Description : Engine-side and pad-side bundle of the SDRAM command-bus
//                arbiter: init/refresh/client command sources and device pins.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sdram_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ROW_W  = 12,
    parameter int BANK_W = 2,
    parameter int DQ_W   = 16
);
    logic                       init_end;
    logic [3:0]                 init_cmd;
    logic [ROW_W-1:0]           init_addr;
    logic                       aref_ask;
    logic                       aref_end;
    logic [3:0]                 aref_cmd;
    logic [ROW_W-1:0]           aref_addr;
    logic                       aref_en;
    logic [NUM_CH-1:0]          ch_ask;
    logic [NUM_CH-1:0]          ch_end;
    logic [4*NUM_CH-1:0]        ch_cmd;
    logic [ROW_W*NUM_CH-1:0]    ch_addr;
    logic [BANK_W*NUM_CH-1:0]   ch_bank;
    logic [DQ_W*NUM_CH-1:0]     ch_wdata;
    logic [NUM_CH-1:0]          ch_dq_oe;
    logic [NUM_CH-1:0]          ch_en;
    logic [2:0]                 grant_id;
    logic                       busy;
    logic [3:0]                 sdram_cmd;
    logic [ROW_W-1:0]           sdram_addr;
    logic [BANK_W-1:0]          sdram_bank;
    logic [DQ_W-1:0]            sdram_dq_out;
    logic                       sdram_dq_oe;
    logic                       wdt_err;

    modport slave (
        input  init_end, init_cmd, init_addr,
        input  aref_ask, aref_end, aref_cmd, aref_addr,
        input  ch_ask, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_dq_oe,
        output aref_en, ch_en, grant_id, busy,
        output sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe,
        output wdt_err
    );

    modport master (
        output init_end, init_cmd, init_addr,
        output aref_ask, aref_end, aref_cmd, aref_addr,
        output ch_ask, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_dq_oe,
        input  aref_en, ch_en, grant_id, busy,
        input  sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe,
        input  wdt_err
    );
endinterface

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
//  Module      : sdram_arbiter
//  Description : SDRAM command-bus arbiter: power-up init pass-through, then
//                refresh-first / round-robin client arbitration and pin mux.
//                Optional watchdog on refresh/client tenure: SDRAM_ARB_WDT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ROW_W   = 12,
    parameter int BANK_W  = 2,
    parameter int DQ_W    = 16,
    parameter int WDT_MAX = 1023
) (
    input  wire logic          sclk,
    input  wire logic          srst,
    sdram_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_ARBIT = 2'd1,
        S_AREF  = 2'd2,
        S_CH    = 2'd3
    } state_t;

    localparam logic [3:0] c_num_ch  = 4'(NUM_CH);
    localparam logic [2:0] c_gnt_rst = 3'(NUM_CH - 1);
    localparam logic [3:0] c_nop     = 4'b0111;

    state_t       r_state;
    logic [2:0]   r_gnt;

    logic [7:0]   w_ask8;
    logic [7:0]   w_end8;
    logic [7:0]   w_oe8;
    logic [2:0]   w_next_gnt;
    logic         w_found;
    logic [2:0]   w_sel;

    logic [3:0]        w_cmd_a   [8];
    logic [ROW_W-1:0]  w_addr_a  [8];
    logic [BANK_W-1:0] w_bank_a  [8];
    logic [DQ_W-1:0]   w_wdata_a [8];

    assign w_ask8 = 8'(bus.ch_ask);
    assign w_end8 = 8'(bus.ch_end);
    assign w_oe8  = 8'(bus.ch_dq_oe);

    // Lanes beyond NUM_CH read as zero so every 3-bit index is safe.
    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_lane
            if (i < NUM_CH) begin : g_used
                assign w_cmd_a[i]   = bus.ch_cmd[4*i +: 4];
                assign w_addr_a[i]  = bus.ch_addr[ROW_W*i +: ROW_W];
                assign w_bank_a[i]  = bus.ch_bank[BANK_W*i +: BANK_W];
                assign w_wdata_a[i] = bus.ch_wdata[DQ_W*i +: DQ_W];
                assign bus.ch_en[i] = (r_state == S_CH) && !bus.aref_ask
                                      && (r_gnt == 3'(i));
            end else begin : g_pad
                assign w_cmd_a[i]   = '0;
                assign w_addr_a[i]  = '0;
                assign w_bank_a[i]  = '0;
                assign w_wdata_a[i] = '0;
            end
        end
    endgenerate

    // Round-robin search starting just after the last grant, wrapping at NUM_CH.
    always_comb begin
        w_found    = 1'b0;
        w_next_gnt = r_gnt;
        for (int k = 1; k <= NUM_CH; k++) begin
            logic [3:0] v_idx;
            v_idx = {1'b0, r_gnt} + 4'(k);
            if (v_idx >= c_num_ch) v_idx = v_idx - c_num_ch;
            if (!w_found && w_ask8[v_idx[2:0]]) begin
                w_found    = 1'b1;
                w_next_gnt = v_idx[2:0];
            end
        end
    end

    assign w_sel = ({1'b0, r_gnt} < c_num_ch) ? r_gnt : 3'd0;

`ifdef SDRAM_ARB_WDT_EN
    localparam logic [9:0] c_wdt_lim = 10'(WDT_MAX - 1);

    logic [9:0] r_wdt_cnt;
    logic       r_wdt_err;
    logic       w_tenure;
    logic       w_done;
    logic       w_wdt_hit;

    assign w_tenure  = (r_state == S_AREF) || (r_state == S_CH);
    assign w_done    = ((r_state == S_AREF) && bus.aref_end)
                     || ((r_state == S_CH) && w_end8[r_gnt]);
    assign w_wdt_hit = w_tenure && !w_done && (r_wdt_cnt == c_wdt_lim);

    always_ff @(posedge sclk) begin
        if (srst) begin
            r_wdt_cnt <= '0;
            r_wdt_err <= 1'b0;
        end else begin
            r_wdt_err <= w_wdt_hit;
            if (w_tenure && !w_done && !w_wdt_hit)
                r_wdt_cnt <= r_wdt_cnt + 10'd1;
            else
                r_wdt_cnt <= '0;
        end
    end

    assign bus.wdt_err = r_wdt_err;
`else
    // Watchdog not built: the compare is constant 0 for any legal limit.
    assign bus.wdt_err = (WDT_MAX < 0);
`endif

    always_ff @(posedge sclk) begin
        if (srst) begin
            r_state <= S_INIT;
            r_gnt   <= c_gnt_rst;
        end else begin
            case (r_state)
                S_INIT:  if (bus.init_end) r_state <= S_ARBIT;
                S_ARBIT: begin
                    if (bus.aref_ask) begin
                        r_state <= S_AREF;
                    end else if (w_found) begin
                        r_state <= S_CH;
                        r_gnt   <= w_next_gnt;
                    end
                end
                S_AREF:  if (bus.aref_end) r_state <= S_ARBIT;
                S_CH:    if (w_end8[r_gnt]) r_state <= S_ARBIT;
                default: r_state <= S_INIT;
            endcase
`ifdef SDRAM_ARB_WDT_EN
            // gnt is left alone so the next search favours the following channel.
            if (w_wdt_hit) r_state <= S_ARBIT;
`endif
        end
    end

    assign bus.aref_en  = (r_state == S_AREF);
    assign bus.grant_id = r_gnt;
    assign bus.busy     = (r_state != S_ARBIT);

    always_comb begin
        bus.sdram_cmd    = c_nop;
        bus.sdram_addr   = '0;
        bus.sdram_bank   = '0;
        bus.sdram_dq_out = '0;
        bus.sdram_dq_oe  = 1'b0;
        case (r_state)
            S_INIT: begin
                bus.sdram_cmd  = bus.init_cmd;
                bus.sdram_addr = bus.init_addr;
            end
            S_AREF: begin
                bus.sdram_cmd  = bus.aref_cmd;
                bus.sdram_addr = bus.aref_addr;
            end
            S_CH: begin
                bus.sdram_cmd    = w_cmd_a[w_sel];
                bus.sdram_addr   = w_addr_a[w_sel];
                bus.sdram_bank   = w_bank_a[w_sel];
                bus.sdram_dq_out = w_wdata_a[w_sel];
                bus.sdram_dq_oe  = w_oe8[w_sel];
            end
            default: ;
        endcase
    end
endmodule

`default_nettype wire
